bram_fifo_writer: RTL and testbench
===================================

BRAM_FIFO_WRITER -- requirements
Module: bram_fifo_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning BRAM address width; depth = 2^ADDR_W = 64.
REQ-002 SHALL have parameter DATA_W, default 8, meaning BRAM word width.
REQ-003 SHALL have port clk  input  1  single clock for all logic; it also drives the BRAM write port.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream word available.
REQ-006 SHALL have port s_data  input  DATA_W  upstream word.
REQ-007 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-008 SHALL have port clear  input  1  synchronous flush request.
REQ-009 SHALL have port rd_ptr  input  ADDR_W+1  reader pointer; the MSB is the wrap bit.
REQ-010 SHALL have port WRADDR  output  ADDR_W  BRAM write address.
REQ-011 SHALL have port DI  output  DATA_W  BRAM write data.
REQ-012 SHALL have port WREN  output  1  BRAM write-port enable.
REQ-013 SHALL have port WE  output  1  BRAM write strobe.
REQ-014 SHALL have port wr_ptr  output  ADDR_W+1  committed write pointer for the reader.
REQ-015 SHALL have port level  output  ADDR_W+1  occupancy.
REQ-016 SHALL have port full  output  1  level equals depth.
REQ-017 SHALL have port ptr_err  output  1  sticky pointer-inconsistency flag.

Function
REQ-018 SHALL implement FSM states INIT, RUN, FULL, FLUSH.
REQ-019 INIT SHALL zero-fill: a counter writes DI=0 with WREN=WE=1 to addresses 0..depth-1, one address per cycle; s_ready SHALL be 0 throughout.
REQ-020 SHALL take INIT -> RUN in the cycle after address depth-1 is written, 64 cycles total at the default depth.
REQ-021 An accept SHALL occur when s_valid && s_ready; s_valid without s_ready SHALL have no effect.
REQ-022 SHALL assert s_ready = 1 only in RUN; it SHALL be combinational from state only, with no dependence on s_valid.
REQ-023 On accept, the cycle after SHALL carry WREN=WE=1, WRADDR=wr_ptr[ADDR_W-1:0] (pre-increment value), DI=s_data; write latency is 1 cycle.
REQ-024 SHALL increment wr_ptr in that same following cycle, modulo 2^(ADDR_W+1), so the MSB toggles on every address wrap (63 -> 0).
REQ-025 Without an accept (outside INIT), WREN=WE=0 the next cycle and DI/WRADDR SHALL hold.
REQ-026 SHALL compute level = wr_ptr - rd_ptr modulo 2^(ADDR_W+1), combinationally from the registered wr_ptr and the input rd_ptr.
REQ-027 SHALL assert full = (level == depth).
REQ-028 SHALL move RUN -> FULL when an accept makes level reach depth.
REQ-029 SHALL move FULL -> RUN when level < depth.
REQ-030 If clear is seen in RUN or FULL, the next state SHALL be FLUSH; no write SHALL be issued for a word offered in the clear cycle; clear SHALL be ignored in INIT.
REQ-031 FLUSH SHALL last 1 cycle: it loads wr_ptr <= rd_ptr (level becomes 0), then goes to RUN.
REQ-032 Simultaneous accept and rd_ptr change SHALL both be reflected in level on the next cycle, with no lost count.
REQ-033 SHALL set ptr_err = 1 and hold it until reset when level > depth is observed (reader overran the writer).

Reset
REQ-034 rst_n low SHALL asynchronously set: state=INIT, init counter=0, wr_ptr=0, WRADDR=0, DI=0, WREN=0, WE=0, ptr_err=0; s_ready therefore reads 0.
REQ-035 Reset asserted mid-INIT or mid-write SHALL abort the operation; after release, zero-fill SHALL restart from address 0.
REQ-036 Deassertion SHALL be synchronized to clk by a two-flop synchronizer inside the block.

Structure
REQ-037 A shared package bram_pkg SHALL hold the FSM state typedef, default ADDR_W/DATA_W, and the DEPTH constant.
REQ-038 SHALL contain one sub-module, wr_ptr_cnt, holding the wrap-bit pointer counter with increment and load, shared with the future reader block.

Verification
REQ-039 Reset release -> WREN=WE=1 for exactly 64 cycles, WRADDR 0..63, DI=0; s_ready rises on cycle 65.
REQ-040 Push 0xA5, 0x3C with rd_ptr=0 -> BRAM[0]=0xA5, BRAM[1]=0x3C, wr_ptr=2, level=2.
REQ-041 Push 64 words with rd_ptr=0 -> full=1, s_ready=0; then set rd_ptr=1 -> full=0, s_ready=1 next cycle.
REQ-042 Wrap: rd_ptr=60, wr_ptr=60, push 6 words -> WRADDR 60..63, 0, 1; wr_ptr=66 (MSB=1), level=6.
REQ-043 clear with wr_ptr=10, rd_ptr=4, s_valid=1 -> no write in the clear cycle, FLUSH for 1 cycle, then wr_ptr=4, level=0.
REQ-044 Drive rd_ptr=5 with wr_ptr=3 -> ptr_err=1 and it stays 1 until rst_n is pulsed low.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: types and default sizing shared by the BRAM FIFO writer and reader blocks.
//   DEF_ADDR_W / DEF_DATA_W : default BRAM address and word widths
//   DEPTH                   : default BRAM depth in words (2**DEF_ADDR_W)
//   wr_state_e              : writer FSM states
package bram_pkg;

  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEPTH      = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StFull,
    StFlush
  } wr_state_e;

endpackage

// File: rtl/bram_fifo_writer_wr_ptr_cnt.sv
// wr_ptr_cnt: wrap-bit FIFO pointer. The extra MSB toggles on every address wrap so that
// full and empty can be told apart by pointer subtraction. Load takes priority over increment.
//   clk_i, rst_ni : clock, active-low async reset (pointer clears to 0)
//   inc_i         : advance the pointer by one (modulo 2**PtrW)
//   load_i        : overwrite the pointer with load_val_i
//   ptr_o         : current registered pointer
module wr_ptr_cnt
  import bram_pkg::*;
#(
  parameter int unsigned PtrW = DEF_ADDR_W + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PtrW-1:0] load_val_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bram_fifo_writer.sv
// bram_fifo_writer: write side of a BRAM-backed FIFO. After reset it zero-fills the whole
// BRAM, then accepts a valid/ready stream and writes each word one cycle later, publishing
// a wrap-bit write pointer for the reader. Occupancy is derived from the reader's pointer.
//   clk, rst_n          : clock, active-low reset (async assert, synchronized release)
//   s_valid/s_data      : upstream word; s_ready high only while running and not full
//   clear               : flush; write pointer snaps to rd_ptr
//   rd_ptr              : reader pointer (MSB = wrap bit)
//   WRADDR/DI/WREN/WE   : BRAM write port (registered)
//   wr_ptr/level/full   : committed write pointer, occupancy, occupancy == depth
//   ptr_err             : sticky, reader ran past the writer
module bram_fifo_writer
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              clear,
  input  logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] WRADDR,
  output logic [DATA_W-1:0] DI,
  output logic              WREN,
  output logic              WE,
  output logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              ptr_err
);

  localparam logic [ADDR_W:0] FifoDepth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LastFill  = {1'b0, {ADDR_W{1'b1}}};

  // Reset release synchronizer; assertion stays asynchronous through the flop clears.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  wr_state_e         state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              wren_q, wren_d;
  logic              ptr_err_q, ptr_err_d;
  logic [ADDR_W:0]   wr_ptr_w, level_w;
  logic              accept, ptr_inc, ptr_load;

  wr_ptr_cnt #(
    .PtrW (ADDR_W + 1)
  ) u_wr_ptr_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_int_n),
    .inc_i      (ptr_inc),
    .load_i     (ptr_load),
    .load_val_i (rd_ptr),
    .ptr_o      (wr_ptr_w)
  );

  assign s_ready = (state_q == StRun);
  // A word offered alongside clear is dropped.
  assign accept  = s_valid & s_ready & ~clear;
  assign level_w = wr_ptr_w - rd_ptr;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wraddr_d   = wraddr_q;
    di_d       = di_q;
    wren_d     = 1'b0;
    ptr_inc    = 1'b0;
    ptr_load   = 1'b0;
    // Any level above depth means the reader is ahead of the writer.
    ptr_err_d  = ptr_err_q | (level_w > FifoDepth);

    unique case (state_q)
      StInit: begin
        // Counter runs one past the last address so RUN starts after the final write.
        if (init_cnt_q == FifoDepth) begin
          state_d = StRun;
        end else begin
          wren_d     = 1'b1;
          wraddr_d   = init_cnt_q[ADDR_W-1:0];
          di_d       = '0;
          init_cnt_d = init_cnt_q + (ADDR_W + 1)'(1);
        end
      end
      StRun: begin
        if (clear) begin
          state_d = StFlush;
        end else if (accept) begin
          wren_d   = 1'b1;
          wraddr_d = wr_ptr_w[ADDR_W-1:0];
          di_d     = s_data;
          ptr_inc  = 1'b1;
          if (level_w == LastFill) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (clear) begin
          state_d = StFlush;
        end else if (level_w < FifoDepth) begin
          state_d = StRun;
        end
      end
      StFlush: begin
        ptr_load = 1'b1;
        state_d  = StRun;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      wraddr_q   <= '0;
      di_q       <= '0;
      wren_q     <= 1'b0;
      ptr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wraddr_q   <= wraddr_d;
      di_q       <= di_d;
      wren_q     <= wren_d;
      ptr_err_q  <= ptr_err_d;
    end
  end

  assign WRADDR  = wraddr_q;
  assign DI      = di_q;
  assign WREN    = wren_q;
  assign WE      = wren_q;
  assign wr_ptr  = wr_ptr_w;
  assign level   = level_w;
  assign full    = (level_w == FifoDepth);
  assign ptr_err = ptr_err_q;

endmodule

// File: tb/tb_bram_fifo_writer.sv
// Bench for bram_fifo_writer: a behavioural FIFO model (integer pointers, memory array)
// is compared with the DUT every cycle, plus directed literal checks.
module tb_bram_fifo_writer;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int DEP = 64;
  localparam int PM  = 127;

  localparam int MInit  = 0;
  localparam int MRun   = 1;
  localparam int MFull  = 2;
  localparam int MFlush = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          clear = 1'b0;
  logic [AW:0]   rd_ptr = '0;
  logic          s_ready, WREN, WE, full, ptr_err;
  logic [AW-1:0] WRADDR;
  logic [DW-1:0] DI;
  logic [AW:0]   wr_ptr, level;

  always #5 clk = ~clk;

  bram_fifo_writer #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .clear   (clear),
    .rd_ptr  (rd_ptr),
    .WRADDR  (WRADDR),
    .DI      (DI),
    .WREN    (WREN),
    .WE      (WE),
    .wr_ptr  (wr_ptr),
    .level   (level),
    .full    (full),
    .ptr_err (ptr_err)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model state.
  bit       m_active = 1'b0;
  int       m_mode, m_init_n, m_wr_ptr, m_lvl;
  bit       m_err, m_acc;
  bit       exp_wren;
  int       exp_wraddr, exp_di;
  logic [7:0] exp_mem [DEP];
  logic [7:0] dut_mem [DEP];
  int       c_lvl;

  always @(posedge clk) begin
    if (m_active && rst_n) begin
      m_lvl = (m_wr_ptr - int'(rd_ptr)) & PM;
      if (m_lvl > DEP) m_err = 1'b1;
      m_acc = s_valid && (m_mode == MRun) && !clear;
      exp_wren = 1'b0;
      case (m_mode)
        MInit: begin
          if (m_init_n < DEP) begin
            exp_wren   = 1'b1;
            exp_wraddr = m_init_n;
            exp_di     = 0;
            exp_mem[m_init_n] = 8'h00;
            m_init_n++;
          end else begin
            m_mode = MRun;
          end
        end
        MRun: begin
          if (clear) begin
            m_mode = MFlush;
          end else if (m_acc) begin
            exp_wren   = 1'b1;
            exp_wraddr = m_wr_ptr % DEP;
            exp_di     = int'(s_data);
            exp_mem[m_wr_ptr % DEP] = s_data;
            m_wr_ptr = (m_wr_ptr + 1) & PM;
            if (((m_wr_ptr - int'(rd_ptr)) & PM) == DEP) m_mode = MFull;
          end
        end
        MFull: begin
          if (clear) m_mode = MFlush;
          else if (m_lvl < DEP) m_mode = MRun;
        end
        default: begin
          m_wr_ptr = int'(rd_ptr);
          m_mode = MRun;
        end
      endcase
    end
  end

  // BRAM image as seen through the DUT write port.
  always @(posedge clk) begin
    if (rst_n && WREN) dut_mem[WRADDR] = DI;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_active && rst_n) begin
      c_lvl = (m_wr_ptr - int'(rd_ptr)) & PM;
      chk("cyc_wren", int'(WREN), int'(exp_wren));
      chk("cyc_we", int'(WE), int'(exp_wren));
      chk("cyc_wraddr", int'(WRADDR), exp_wraddr);
      chk("cyc_di", int'(DI), exp_di);
      chk("cyc_wr_ptr", int'(wr_ptr), m_wr_ptr);
      chk("cyc_level", int'(level), c_lvl);
      chk("cyc_full", int'(full), int'(c_lvl == DEP));
      chk("cyc_s_ready", int'(s_ready), int'(m_mode == MRun));
      chk("cyc_ptr_err", int'(ptr_err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset and wait (bounded) for the zero-fill to start; the model begins there.
  task automatic release_reset();
    int  n;
    bit  seen;
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (WREN) seen = 1'b1;
    end
    chk("zero_fill_started", int'(seen), 1);
    chk("reset_release_synchronized", int'(n >= 4 && n <= 5), 1);
    m_mode     = MInit;
    m_init_n   = 1;
    m_wr_ptr   = 0;
    m_err      = 1'b0;
    exp_wren   = 1'b1;
    exp_wraddr = 0;
    exp_di     = 0;
    exp_mem[0] = 8'h00;
    m_active   = 1'b1;
  endtask

  int cnt, n, nz, mm, p_rd;
  int exp_a [6];

  initial begin
    exp_a = '{60, 61, 62, 63, 0, 1};
    for (int i = 0; i < DEP; i++) begin
      dut_mem[i] = 8'hFF;
      exp_mem[i] = 8'h00;
    end

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wren", int'(WREN), 0);
    chk("rst_we", int'(WE), 0);
    chk("rst_wraddr", int'(WRADDR), 0);
    chk("rst_di", int'(DI), 0);
    chk("rst_wr_ptr", int'(wr_ptr), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_ptr_err", int'(ptr_err), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_full", int'(full), 0);

    // Abort zero-fill midway with an asynchronous reset.
    tick();
    release_reset();
    repeat (20) tick();
    m_active = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wren", int'(WREN), 0);
    chk("abort_wraddr", int'(WRADDR), 0);
    chk("abort_s_ready", int'(s_ready), 0);
    repeat (2) tick();

    // Full zero-fill from address 0.
    release_reset();
    cnt = 1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (WREN) cnt++;
    end
    chk("init_write_cycles", cnt, 64);
    chk("ready_rise_cycle", n + 1, 65);
    chk("ready_rise_wren_low", int'(WREN), 0);
    nz = 0;
    for (int i = 0; i < DEP; i++) if (dut_mem[i] !== 8'h00) nz++;
    chk("zero_fill_nonzero_words", nz, 0);

    // Two pushes.
    s_valid = 1'b1;
    s_data = 8'hA5;
    tick();
    s_data = 8'h3C;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    chk("bram0", int'(dut_mem[0]), 8'hA5);
    chk("bram1", int'(dut_mem[1]), 8'h3C);
    chk("two_push_wr_ptr", int'(wr_ptr), 2);
    chk("two_push_level", int'(level), 2);

    // Fill to depth, one extra offer while full, then the reader frees a slot.
    s_valid = 1'b1;
    for (int i = 0; i < 62; i++) begin
      s_data = 8'($urandom);
      tick();
    end
    s_data = 8'hEE;
    tick();
    s_valid = 1'b0;
    chk("fill_full", int'(full), 1);
    chk("fill_s_ready", int'(s_ready), 0);
    chk("fill_wr_ptr", int'(wr_ptr), 64);
    rd_ptr = 7'd1;
    #1;
    chk("drain_full_comb", int'(full), 0);
    chk("drain_s_ready_same_cycle", int'(s_ready), 0);
    tick();
    chk("drain_s_ready_next", int'(s_ready), 1);

    // Wrap across address 63.
    rd_ptr = 7'd60;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("wrap_start_wr_ptr", int'(wr_ptr), 60);
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'($urandom);
      tick();
      chk("wrap_wren", int'(WREN), 1);
      chk("wrap_wraddr", int'(WRADDR), exp_a[i]);
    end
    s_valid = 1'b0;
    chk("wrap_wr_ptr", int'(wr_ptr), 66);
    chk("wrap_msb", int'(wr_ptr[AW]), 1);
    chk("wrap_level", int'(level), 6);

    // Clear with a word on offer.
    rd_ptr = 7'd10;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clr_setup_wr_ptr", int'(wr_ptr), 10);
    rd_ptr = 7'd4;
    s_valid = 1'b1;
    s_data = 8'h77;
    clear = 1'b1;
    tick();
    chk("clr_no_write", int'(WREN), 0);
    chk("clr_flush_not_ready", int'(s_ready), 0);
    clear = 1'b0;
    s_valid = 1'b0;
    tick();
    chk("clr_wr_ptr", int'(wr_ptr), 4);
    chk("clr_level", int'(level), 0);
    chk("clr_ready_again", int'(s_ready), 1);

    // Randomized traffic with a well-behaved reader and occasional clears.
    for (int ph = 0; ph < 3; ph++) begin
      p_rd = (ph == 0) ? 70 : ((ph == 1) ? 15 : 95);
      for (int k = 0; k < 400; k++) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = 8'($urandom);
        clear   = ($urandom_range(0, 79) == 0);
        if (((m_wr_ptr - int'(rd_ptr)) & PM) > 0 && $urandom_range(0, 99) < p_rd)
          rd_ptr = rd_ptr + 7'd1;
        tick();
      end
    end
    s_valid = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    mm = 0;
    for (int i = 0; i < DEP; i++) if (dut_mem[i] !== exp_mem[i]) mm++;
    chk("bram_contents_mismatches", mm, 0);

    // Steer wr_ptr to 3 with the reader tracking it, then let the reader overrun.
    n = 0;
    s_valid = 1'b1;
    while (m_wr_ptr != 3 && n < 200) begin
      rd_ptr = 7'(m_wr_ptr);
      s_data = 8'($urandom);
      tick();
      n++;
    end
    s_valid = 1'b0;
    rd_ptr = 7'd3;
    tick();
    chk("err_setup_wr_ptr", int'(wr_ptr), 3);
    chk("err_before", int'(ptr_err), 0);
    rd_ptr = 7'd5;
    tick();
    chk("err_level", int'(level), 126);
    chk("err_set", int'(ptr_err), 1);
    rd_ptr = 7'd3;
    repeat (3) tick();
    chk("err_sticky", int'(ptr_err), 1);
    m_active = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("err_cleared_by_reset", int'(ptr_err), 0);
    chk("err_reset_wr_ptr", int'(wr_ptr), 0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
